keypad_entry: RTL and testbench

- Reads a 4x4 hexadecimal matrix keypad and turns key presses into a packed hex value that the N-digit seven-segment display driver consumes.
- Drives the keypad columns one at a time, samples the rows, debounces the result and accepts each key press once.
- Shifts each accepted digit into an NDIG-digit register, with the newest digit in the least-significant nibble.

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/keypad_entry_if.sv | 33 +++
 rtl/keypad_scanner.sv | 112 +++++++++++
 rtl/keypad_entry.sv | 149 ++++++++++++++
 tb/tb_keypad_entry.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and the key map for the hex keypad entry block.
//   kp_state_t : debounce FSM states
//   scan_res_t : outcome of one full keypad scan
//   KEY_MAP    : hex code of the key at [row][column]
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD
    } kp_state_t;

    typedef enum logic [1:0] {
        R_NONE,
        R_KEY,
        R_MULTI
    } scan_res_t;

    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

endpackage

// File: rtl/keypad_entry_if.sv
// Keypad matrix lines plus the entered-value bus seen by the display.
//   col_n       : column drive, active-low one-hot (block -> keypad)
//   row_n       : row sense, active-low, asynchronous (keypad -> block)
//   clear       : synchronous clear of the entered value
//   value       : NDIG packed hex digits, nibble 0 newest
//   key_code    : code of the last accepted key
//   key_valid   : one-clock pulse per accepted key
//   digit_count : digits entered, saturating at NDIG
interface keypad_entry_if #(
    parameter int unsigned NDIG = 8
);
    localparam int unsigned VW = NDIG * 4;
    localparam int unsigned DW = $clog2(NDIG + 1);

    logic [3:0]    col_n;
    logic [3:0]    row_n;
    logic          clear;
    logic [VW-1:0] value;
    logic [3:0]    key_code;
    logic          key_valid;
    logic [DW-1:0] digit_count;

    modport master (
        output row_n, clear,
        input  col_n, value, key_code, key_valid, digit_count
    );

    modport slave (
        input  row_n, clear,
        output col_n, value, key_code, key_valid, digit_count
    );

endinterface

// File: rtl/keypad_scanner.sv
// Column scanner: synchronizes the rows, walks the columns and condenses each
// full scan into one result.
//   clock, reset : system clock, synchronous active-high reset
//   row_n        : raw row sense (asynchronous)
//   col_n        : registered column drive
//   scan_done_c  : high on the clock that samples column 3
//   scan_res_c   : NONE / KEY / MULTI for the scan ending this clock
//   scan_code_c  : key code when scan_res_c is R_KEY
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       scan_done_c,
    output scan_res_t  scan_res_c,
    output logic [3:0] scan_code_c
);

    localparam int unsigned TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [TW-1:0] tick_q;
    logic [1:0]    col_q;
    logic [3:0]    col_n_q;
    logic [1:0]    acc_hits_q;   // 0, 1, or 2 meaning "more than one"
    logic [3:0]    acc_code_q;

    logic          sample_c;
    logic [3:0]    hit_c;
    logic [2:0]    col_hits_c;
    logic [3:0]    col_code_c;
    logic [1:0]    tot_hits_c;
    logic [3:0]    tot_code_c;

    assign sample_c = (tick_q == TICK_LAST);
    assign hit_c    = ~row_sync;

    // Hits in the current column and the code of the (last) hit row
    always_comb begin
        col_hits_c = '0;
        col_code_c = '0;
        for (int r = 0; r < 4; r++) begin
            if (hit_c[r]) begin
                col_hits_c = col_hits_c + 3'd1;
                col_code_c = KEY_MAP[2'(r)][col_q];
            end
        end
    end

    // Merge this column into the running scan totals
    always_comb begin
        tot_hits_c = acc_hits_q;
        tot_code_c = acc_code_q;
        if ((col_hits_c > 3'd1) || ((col_hits_c == 3'd1) && (acc_hits_q != 2'd0))) begin
            tot_hits_c = 2'd2;
        end else if (col_hits_c == 3'd1) begin
            tot_hits_c = 2'd1;
            tot_code_c = col_code_c;
        end
    end

    assign scan_done_c = sample_c && (col_q == 2'd3);
    assign scan_code_c = tot_code_c;

    always_comb begin
        scan_res_c = R_NONE;
        if (tot_hits_c == 2'd1) begin
            scan_res_c = R_KEY;
        end else if (tot_hits_c == 2'd2) begin
            scan_res_c = R_MULTI;
        end
    end

    // Synchronizer, tick counter, column rotation and scan accumulators
    always_ff @(posedge clock) begin
        if (reset) begin
            row_meta   <= 4'hF;
            row_sync   <= 4'hF;
            tick_q     <= '0;
            col_q      <= '0;
            col_n_q    <= 4'b1110;
            acc_hits_q <= '0;
            acc_code_q <= '0;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
            if (sample_c) begin
                tick_q  <= '0;
                col_q   <= col_q + 2'd1;
                col_n_q <= {col_n_q[2:0], col_n_q[3]};
                if (col_q == 2'd3) begin
                    acc_hits_q <= '0;
                    acc_code_q <= '0;
                end else begin
                    acc_hits_q <= tot_hits_c;
                    acc_code_q <= tot_code_c;
                end
            end else begin
                tick_q <= tick_q + 1'b1;
            end
        end
    end

    assign col_n = col_n_q;

endmodule

// File: rtl/keypad_entry.sv
// Hex keypad entry: debounces scan results and shifts accepted keys into an
// NDIG-digit value for the seven-segment display.
//   clock, reset : system clock, synchronous active-high reset
//   bus          : keypad lines and entered-value outputs (slave side)
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int unsigned NDIG           = 8,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic          clock,
    input  logic          reset,
    keypad_entry_if.slave bus
);

    localparam int unsigned VW = NDIG * 4;
    localparam int unsigned DW = $clog2(NDIG + 1);
    localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS);
    localparam logic [DW-1:0] DIG_MAX  = DW'(NDIG);

    logic       scan_done_c;
    scan_res_t  scan_res_c;
    logic [3:0] scan_code_c;

    kp_state_t     state_q, state_n;
    logic [3:0]    cand_q, cand_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [CW-1:0] rel_q, rel_n;
    logic          accept_c;

    logic [VW-1:0] value_q;
    logic [3:0]    key_code_q;
    logic          key_valid_q;
    logic [DW-1:0] digit_q;

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scanner (
        .clock       (clock),
        .reset       (reset),
        .row_n       (bus.row_n),
        .col_n       (bus.col_n),
        .scan_done_c (scan_done_c),
        .scan_res_c  (scan_res_c),
        .scan_code_c (scan_code_c)
    );

    // FSM state register with its candidate and counters
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            rel_q   <= '0;
        end else begin
            state_q <= state_n;
            cand_q  <= cand_n;
            cnt_q   <= cnt_n;
            rel_q   <= rel_n;
        end
    end

    // Next state: only a scan end moves the FSM
    always_comb begin
        state_n = state_q;
        cand_n  = cand_q;
        cnt_n   = cnt_q;
        rel_n   = rel_q;
        if (scan_done_c) begin
            case (state_q)
                IDLE: begin
                    if (scan_res_c == R_KEY) begin
                        cand_n  = scan_code_c;
                        cnt_n   = CW'(1);
                        rel_n   = '0;
                        state_n = (CNT_LAST == CW'(1)) ? HELD : DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if ((scan_res_c == R_KEY) && (scan_code_c == cand_q)) begin
                        cnt_n = cnt_q + 1'b1;
                        if (cnt_n == CNT_LAST) begin
                            state_n = HELD;
                            rel_n   = '0;
                        end
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                HELD: begin
                    if (scan_res_c == R_NONE) begin
                        rel_n = rel_q + 1'b1;
                        if (rel_n == CNT_LAST) begin
                            state_n = IDLE;
                            rel_n   = '0;
                            cnt_n   = '0;
                        end
                    end else begin
                        rel_n = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Accept is the transition into HELD
    always_comb begin
        accept_c = 1'b0;
        if (scan_done_c && (state_q != HELD) && (state_n == HELD)) begin
            accept_c = 1'b1;
        end
    end

    // Output registers; clear overrides an accept for value and count only
    always_ff @(posedge clock) begin
        if (reset) begin
            value_q     <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            digit_q     <= '0;
        end else begin
            key_valid_q <= accept_c;
            if (accept_c) begin
                key_code_q <= cand_n;
            end
            if (bus.clear) begin
                value_q <= '0;
                digit_q <= '0;
            end else if (accept_c) begin
                value_q <= {value_q[VW-5:0], cand_n};
                if (digit_q != DIG_MAX) begin
                    digit_q <= digit_q + 1'b1;
                end
            end
        end
    end

    assign bus.value       = value_q;
    assign bus.key_code    = key_code_q;
    assign bus.key_valid   = key_valid_q;
    assign bus.digit_count = digit_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a keypad model drives rows from the column drive and
// a pressed-key mask; a scan-level reference model predicts every output.
module tb_keypad_entry;

    localparam int NDIG      = 4;
    localparam int SCAN_DIV  = 4;
    localparam int DS        = 2;
    localparam int SCAN_CLKS = 4 * SCAN_DIV;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    keypad_entry_if #(.NDIG(NDIG)) bus ();

    keypad_entry #(
        .NDIG           (NDIG),
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Key at index row*4+col
    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

    logic [15:0] mask = '0;

    // Keypad: a pressed key shorts its row to the driven-low column
    always_comb begin
        bus.row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!bus.col_n[c] && mask[r*4+c]) bus.row_n[r] = 1'b0;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] km(input logic [3:0] d);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) if (kmap[i] == d) m = 16'(1) << i;
        return m;
    endfunction

    // Reference model, advanced once per full scan
    int          m_phase;   // 0 waiting, 1 confirming, 2 key held
    logic [3:0]  m_cand;
    int          m_run;
    int          m_quiet;
    logic [15:0] m_value;
    int          m_count;
    logic [3:0]  m_code;
    bit          m_pending;

    task automatic model_reset();
        m_phase = 0; m_cand = '0; m_run = 0; m_quiet = 0;
        m_value = '0; m_count = 0; m_code = '0; m_pending = 0;
    endtask

    task automatic model_accept();
        m_pending = 1;
        m_code    = m_cand;
        m_value   = {m_value[11:0], m_cand};
        if (m_count < NDIG) m_count++;
    endtask

    task automatic model_scan(input logic [15:0] m);
        int         n;
        logic [3:0] k;
        n = $countones(m);
        k = '0;
        for (int i = 0; i < 16; i++) if (m[i]) k = kmap[i];
        m_pending = 0;
        case (m_phase)
            0: if (n == 1) begin
                m_cand = k; m_run = 1; m_phase = 1;
                if (m_run >= DS) begin model_accept(); m_phase = 2; m_quiet = 0; end
            end
            1: if (n == 1 && k == m_cand) begin
                m_run++;
                if (m_run >= DS) begin model_accept(); m_phase = 2; m_quiet = 0; end
            end else begin
                m_phase = 0;
            end
            default: begin
                if (n == 0) m_quiet++; else m_quiet = 0;
                if (m_quiet >= DS) m_phase = 0;
            end
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b1; mask = '0; bus.clear = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
    endtask

    // One full scan starting just after a scan boundary; clear pulses on cycle clr_at
    task automatic run_scan(input logic [15:0] m, input int clr_at);
        mask = m;
        for (int i = 0; i < SCAN_CLKS; i++) begin
            bus.clear = (i == clr_at);
            @(negedge clock);
            chk("col_n", 32'(bus.col_n), 32'(4'hF ^ (4'b0001 << (i / SCAN_DIV))));
            chk("key_valid", 32'(bus.key_valid), 32'((i == 0) && m_pending));
            chk("value", 32'(bus.value), 32'(m_value));
            chk("digit_count", 32'(bus.digit_count), 32'(m_count));
            chk("key_code", 32'(bus.key_code), 32'(m_code));
            @(posedge clock);
            #1;
            if (i == clr_at && i != SCAN_CLKS - 1) begin m_value = '0; m_count = 0; end
        end
        bus.clear = 1'b0;
        model_scan(m);
        if (clr_at == SCAN_CLKS - 1) begin m_value = '0; m_count = 0; end
    endtask

    typedef struct {
        logic [15:0] mask;
        int          scans;
        int          clr_at;
        logic [15:0] exp_value;
        int          exp_count;
        logic        exp_kv;
        logic [3:0]  exp_code;
    } step_t;

    step_t steps [$];

    function automatic step_t mk(input logic [15:0] m, input int sc, input int clr,
                                 input logic [15:0] v, input int cnt, input logic kv,
                                 input logic [3:0] code);
        step_t s;
        s.mask = m; s.scans = sc; s.clr_at = clr;
        s.exp_value = v; s.exp_count = cnt; s.exp_kv = kv; s.exp_code = code;
        return s;
    endfunction

    initial begin
        logic [15:0] rm;
        int          sel;
        int          hold;
        int          clr;

        bus.clear = 1'b0;
        do_reset();
        chk("rst col_n", 32'(bus.col_n), 32'h0000_000E);
        chk("rst value", 32'(bus.value), 32'h0);
        chk("rst key_valid", 32'(bus.key_valid), 32'h0);
        chk("rst digit_count", 32'(bus.digit_count), 32'h0);

        steps.push_back(mk(16'h0,  4, -1, 16'h0000, 0, 1'b0, 4'h0));
        steps.push_back(mk(km(6),  6, -1, 16'h0006, 1, 1'b0, 4'h6));
        steps.push_back(mk(16'h0,  3, -1, 16'h0006, 1, 1'b0, 4'h6));
        steps.push_back(mk(16'h0,  1,  5, 16'h0000, 0, 1'b0, 4'h6));
        steps.push_back(mk(km(1),  3, -1, 16'h0001, 1, 1'b0, 4'h1));
        steps.push_back(mk(16'h0,  3, -1, 16'h0001, 1, 1'b0, 4'h1));
        steps.push_back(mk(km(10), 3, -1, 16'h001A, 2, 1'b0, 4'hA));
        steps.push_back(mk(16'h0,  3, -1, 16'h001A, 2, 1'b0, 4'hA));
        steps.push_back(mk(km(0),  3, -1, 16'h01A0, 3, 1'b0, 4'h0));
        steps.push_back(mk(16'h0,  3, -1, 16'h01A0, 3, 1'b0, 4'h0));
        steps.push_back(mk(km(13), 3, -1, 16'h1A0D, 4, 1'b0, 4'hD));
        steps.push_back(mk(16'h0,  3, -1, 16'h1A0D, 4, 1'b0, 4'hD));
        steps.push_back(mk(km(14), 3, -1, 16'hA0DE, 4, 1'b0, 4'hE));
        steps.push_back(mk(16'h0,  3, -1, 16'hA0DE, 4, 1'b0, 4'hE));
        for (int b = 0; b < 3; b++) begin
            steps.push_back(mk(km(5), 1, -1, 16'hA0DE, 4, 1'b0, 4'hE));
            steps.push_back(mk(16'h0, 1, -1, 16'hA0DE, 4, 1'b0, 4'hE));
        end
        steps.push_back(mk(km(1) | km(2), 4, -1, 16'hA0DE, 4, 1'b0, 4'hE));
        steps.push_back(mk(16'h0,  3, -1, 16'hA0DE, 4, 1'b0, 4'hE));
        steps.push_back(mk(16'h0,  1,  5, 16'h0000, 0, 1'b0, 4'hE));
        steps.push_back(mk(km(3),  3, -1, 16'h0003, 1, 1'b0, 4'h3));
        steps.push_back(mk(16'h0,  1, -1, 16'h0003, 1, 1'b0, 4'h3));
        steps.push_back(mk(km(3),  2, -1, 16'h0003, 1, 1'b0, 4'h3));
        steps.push_back(mk(16'h0,  2, -1, 16'h0003, 1, 1'b0, 4'h3));
        steps.push_back(mk(km(3),  3, -1, 16'h0033, 2, 1'b0, 4'h3));
        steps.push_back(mk(16'h0,  3, -1, 16'h0033, 2, 1'b0, 4'h3));
        steps.push_back(mk(km(7),  2, SCAN_CLKS - 1, 16'h0000, 0, 1'b1, 4'h7));
        steps.push_back(mk(16'h0,  3, -1, 16'h0000, 0, 1'b0, 4'h7));

        foreach (steps[j]) begin
            for (int s = 0; s < steps[j].scans; s++) begin
                run_scan(steps[j].mask, (s == steps[j].scans - 1) ? steps[j].clr_at : -1);
            end
            chk($sformatf("step%0d value", j), 32'(bus.value), 32'(steps[j].exp_value));
            chk($sformatf("step%0d digit_count", j), 32'(bus.digit_count), 32'(steps[j].exp_count));
            chk($sformatf("step%0d key_valid", j), 32'(bus.key_valid), 32'(steps[j].exp_kv));
            chk($sformatf("step%0d key_code", j), 32'(bus.key_code), 32'(steps[j].exp_code));
        end

        // Random presses, bounces, chords and occasional clears
        for (int n = 0; n < 25; n++) begin
            sel  = int'($urandom_range(0, 9));
            hold = int'($urandom_range(1, 4));
            if (sel < 4) rm = '0;
            else if (sel < 8) rm = 16'(1) << $urandom_range(0, 15);
            else rm = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            for (int h = 0; h < hold; h++) begin
                clr = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, SCAN_CLKS - 1)) : -1;
                run_scan(rm, clr);
            end
        end

        // Reset in the middle of a debounce: no pulse, reset values back
        for (int s = 0; s < 3; s++) run_scan(km(8), -1);
        for (int s = 0; s < 2; s++) run_scan(16'h0, -1);
        run_scan(km(9), -1);
        mask = km(9);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("mid-debounce key_valid", 32'(bus.key_valid), 32'h0);
            @(posedge clock);
            #1;
        end
        do_reset();
        chk("rst2 col_n", 32'(bus.col_n), 32'h0000_000E);
        chk("rst2 value", 32'(bus.value), 32'h0);
        chk("rst2 key_code", 32'(bus.key_code), 32'h0);
        chk("rst2 key_valid", 32'(bus.key_valid), 32'h0);
        chk("rst2 digit_count", 32'(bus.digit_count), 32'h0);
        for (int s = 0; s < 3; s++) run_scan(16'h0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
